// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: derived layer geometry helpers and sequencer state shared by the conv step sequencer
package conv_seq_pkg;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    function automatic int calc_iw(input int ofm, input int stride, input int k);
        return (ofm - 1) * stride + k;
    endfunction

    function automatic int calc_steps(input int k, input int ifm_c);
        return k * k * ifm_c;
    endfunction

    function automatic int calc_tiles(input int npix, input int num_pe);
        return (npix + num_pe - 1) / num_pe;
    endfunction

    function automatic int calc_last_pix(input int npix, input int num_pe);
        return npix - (calc_tiles(npix, num_pe) - 1) * num_pe;
    endfunction

endpackage

// File: rtl/conv_tile_origin.sv
// conv_tile_origin: PE0 output coordinate with constant-step carry, and the per-tile PE active mask
module conv_tile_origin
    import conv_seq_pkg::*;
#(
    parameter int NUM_PE = 256,
    parameter int OFM_W  = 32,
    parameter int OFM_H  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              zero,
    input  logic              clear,
    input  logic              advance,
    input  logic              last,
    output logic [15:0]       ox0,
    output logic [15:0]       oy0,
    output logic [15:0]       nx,
    output logic [15:0]       ny,
    output logic [NUM_PE-1:0] pe_mask
);
    localparam int TILES = calc_tiles(OFM_W * OFM_H, NUM_PE);
    localparam int LAST  = calc_last_pix(OFM_W * OFM_H, NUM_PE);
    localparam logic [NUM_PE-1:0] ALL   = '1;
    localparam logic [NUM_PE-1:0] PART  = ALL >> (NUM_PE - LAST);
    localparam logic [NUM_PE-1:0] FIRST = (TILES == 1) ? PART : ALL;
    localparam logic [15:0] DX = 16'(NUM_PE % OFM_W);
    localparam logic [15:0] DY = 16'(NUM_PE / OFM_W);

    logic [15:0] sx;
    logic        carry;

    // next tile origin: step x by the width remainder, wrap into y
    always_comb begin
        sx    = ox0 + DX;
        carry = sx >= 16'(OFM_W);
        nx    = carry ? sx - 16'(OFM_W) : sx;
        ny    = oy0 + DY + {15'd0, carry};
    end

    // origin and mask registers, reloaded at each filter and stepped at each tile
    always_ff @(posedge clk or posedge rst) begin
        if (rst || zero) begin
            ox0     <= '0;
            oy0     <= '0;
            pe_mask <= '0;
        end else if (clear) begin
            ox0     <= '0;
            oy0     <= '0;
            pe_mask <= FIRST;
        end else if (advance) begin
            ox0     <= nx;
            oy0     <= ny;
            pe_mask <= last ? PART : ALL;
        end
    end

endmodule

// File: rtl/conv_step_sequencer.sv
// conv_step_sequencer: walks filters, tiles, channels and kernel taps to drive PE-array operand fetch
module conv_step_sequencer
    import conv_seq_pkg::*;
#(
    parameter int NUM_PE  = 256,
    parameter int K       = 3,
    parameter int IFM_C   = 3,
    parameter int OFM_C   = 2,
    parameter int OFM_W   = 32,
    parameter int OFM_H   = 32,
    parameter int STRIDE  = 1,
    parameter int ADDR_W  = 16,
    parameter int WADDR_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step_ready,
    output logic               step_valid,
    output logic [ADDR_W-1:0]  ifm_addr,
    output logic [WADDR_W-1:0] weight_addr,
    output logic [15:0]        ox0,
    output logic [15:0]        oy0,
    output logic [NUM_PE-1:0]  pe_mask,
    output logic               pe_restart,
    output logic               pe_finish,
    output logic               tile_done,
    output logic               busy,
    output logic               done
);
    localparam int IW    = calc_iw(OFM_W, STRIDE, K);
    localparam int IH    = calc_iw(OFM_H, STRIDE, K);
    localparam int STEPS = calc_steps(K, IFM_C);
    localparam int TILES = calc_tiles(OFM_W * OFM_H, NUM_PE);
    localparam logic [ADDR_W-1:0]  ROW_STEP = ADDR_W'(IW - (K - 1));
    localparam logic [ADDR_W-1:0]  CH_STEP  = ADDR_W'(IW * IH - (K - 1) * IW - (K - 1));
    localparam logic [WADDR_W-1:0] REWIND   = WADDR_W'(STEPS - 1);

    state_t             state;
    logic [15:0]        kx, ky, c, tile, f, kx_n, ky_n, c_n, tile_n, nx, ny;
    logic               fire, lkx, lky, lc, lt, lf, adv_c, end_tile, end_layer;
    logic [ADDR_W-1:0]  ifm_n, base_n;
    logic [WADDR_W-1:0] weight_n;

    // next loop indices and incrementally stepped addresses for the step after a handshake
    always_comb begin
        fire      = step_valid && step_ready;
        lkx       = kx == 16'(K - 1);
        lky       = ky == 16'(K - 1);
        lc        = c == 16'(IFM_C - 1);
        lt        = tile == 16'(TILES - 1);
        lf        = f == 16'(OFM_C - 1);
        adv_c     = lkx && lky;
        end_tile  = adv_c && lc;
        end_layer = end_tile && lt && lf;
        kx_n      = lkx ? 16'd0 : kx + 16'd1;
        ky_n      = lkx ? (lky ? 16'd0 : ky + 16'd1) : ky;
        c_n       = adv_c ? (lc ? 16'd0 : c + 16'd1) : c;
        tile_n    = end_tile ? (lt ? 16'd0 : tile + 16'd1) : tile;
        base_n    = ADDR_W'(32'(ny) * STRIDE * IW + 32'(nx) * STRIDE);
        ifm_n     = end_tile ? (lt ? '0 : base_n) :
                    adv_c    ? ifm_addr + CH_STEP :
                    lkx      ? ifm_addr + ROW_STEP : ifm_addr + ADDR_W'(1);
        weight_n  = (end_tile && !lt) ? weight_addr - REWIND : weight_addr + WADDR_W'(1);
    end

    conv_tile_origin #(
        .NUM_PE (NUM_PE),
        .OFM_W  (OFM_W),
        .OFM_H  (OFM_H)
    ) u_origin (
        .clk     (clk),
        .rst     (rst),
        .zero    (fire && end_layer),
        .clear   ((state == S_IDLE && start) || (fire && end_tile && lt && !lf)),
        .advance (fire && end_tile && !lt),
        .last    (tile_n == 16'(TILES - 1)),
        .ox0     (ox0),
        .oy0     (oy0),
        .nx      (nx),
        .ny      (ny),
        .pe_mask (pe_mask)
    );

    // layer FSM; every step output is registered and only moves on a handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            step_valid  <= 1'b0;
            busy        <= 1'b0;
            tile_done   <= 1'b0;
            done        <= 1'b0;
            pe_restart  <= 1'b0;
            pe_finish   <= 1'b0;
            ifm_addr    <= '0;
            weight_addr <= '0;
            kx          <= '0;
            ky          <= '0;
            c           <= '0;
            tile        <= '0;
            f           <= '0;
        end else begin
            tile_done <= 1'b0;
            done      <= 1'b0;
            if (state == S_IDLE && start) begin
                state      <= S_RUN;
                busy       <= 1'b1;
                step_valid <= 1'b1;
                pe_restart <= 1'b1;
                pe_finish  <= (STEPS == 1);
            end else if (fire) begin
                tile_done <= end_tile;
                if (end_layer) begin
                    state       <= S_IDLE;
                    busy        <= 1'b0;
                    step_valid  <= 1'b0;
                    done        <= 1'b1;
                    pe_restart  <= 1'b0;
                    pe_finish   <= 1'b0;
                    ifm_addr    <= '0;
                    weight_addr <= '0;
                    kx          <= '0;
                    ky          <= '0;
                    c           <= '0;
                    tile        <= '0;
                    f           <= '0;
                end else begin
                    kx          <= kx_n;
                    ky          <= ky_n;
                    c           <= c_n;
                    tile        <= tile_n;
                    f           <= (end_tile && lt) ? f + 16'd1 : f;
                    ifm_addr    <= ifm_n;
                    weight_addr <= weight_n;
                    pe_restart  <= kx_n == 16'd0 && ky_n == 16'd0 && c_n == 16'd0;
                    pe_finish   <= kx_n == 16'(K - 1) && ky_n == 16'(K - 1) && c_n == 16'(IFM_C - 1);
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_step_sequencer.sv
// tb_conv_step_sequencer: three sequencer configurations checked every cycle against an index-based model
module tb_conv_step_sequencer;

    typedef struct {
        int ifm, wa, ox, oy, cnt;
        bit rs, fin;
    } exp_t;

    localparam int NSTEP = 27;

    int c_npe[3] = '{256, 64, 16};
    int c_w[3]   = '{32, 10, 16};
    int c_s[3]   = '{1, 1, 2};

    logic clk = 1'b0, rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic rdy_a = 1'b1, rdy_b = 1'b1, rdy_c = 1'b1;
    logic [255:0] ones = '1;

    logic a_v, a_rs, a_fin, a_td, a_bz, a_dn;
    logic b_v, b_rs, b_fin, b_td, b_bz, b_dn;
    logic c_v, c_rs, c_fin, c_td, c_bz, c_dn;
    logic [15:0] a_ifm, a_ox, a_oy, b_ifm, b_ox, b_oy, c_ifm, c_ox, c_oy;
    logic [11:0] a_w, b_w, c_w_o;
    logic [255:0] a_m;
    logic [63:0]  b_m;
    logic [15:0]  c_m;

    int checks = 0, errors = 0;
    bit run[3], etd[3], edone[3], cap[3], replay[3], stall[3];
    int n[3], hs[3];
    logic [317:0] snap[3];
    int o_ifm[3][1024], o_wa[3][1024], o_ox[3][1024], o_oy[3][1024];
    bit o_rs[3][1024], o_fin[3][1024];
    logic [255:0] o_m[3][1024];

    always #5 clk = ~clk;

    conv_step_sequencer dut_a (
        .clk(clk), .rst(rst), .start(start_a), .step_ready(rdy_a), .step_valid(a_v),
        .ifm_addr(a_ifm), .weight_addr(a_w), .ox0(a_ox), .oy0(a_oy), .pe_mask(a_m),
        .pe_restart(a_rs), .pe_finish(a_fin), .tile_done(a_td), .busy(a_bz), .done(a_dn)
    );

    conv_step_sequencer #(.NUM_PE(64), .OFM_W(10), .OFM_H(10)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .step_ready(rdy_b), .step_valid(b_v),
        .ifm_addr(b_ifm), .weight_addr(b_w), .ox0(b_ox), .oy0(b_oy), .pe_mask(b_m),
        .pe_restart(b_rs), .pe_finish(b_fin), .tile_done(b_td), .busy(b_bz), .done(b_dn)
    );

    conv_step_sequencer #(.NUM_PE(16), .OFM_W(16), .OFM_H(16), .STRIDE(2)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .step_ready(rdy_c), .step_valid(c_v),
        .ifm_addr(c_ifm), .weight_addr(c_w_o), .ox0(c_ox), .oy0(c_oy), .pe_mask(c_m),
        .pe_restart(c_rs), .pe_finish(c_fin), .tile_done(c_td), .busy(c_bz), .done(c_dn)
    );

    function automatic int tiles_of(input int d);
        return (c_w[d] * c_w[d] + c_npe[d] - 1) / c_npe[d];
    endfunction

    function automatic int total_of(input int d);
        return 2 * tiles_of(d) * NSTEP;
    endfunction

    // expected step contents straight from the step index: decompose into f/tile/c/ky/kx
    function automatic exp_t model(input int d, input int idx);
        exp_t e;
        int npe, w, s, iw, tl, st, t, f, kx, ky, ch, p0;
        npe   = c_npe[d];
        w     = c_w[d];
        s     = c_s[d];
        iw    = (w - 1) * s + 3;
        tl    = tiles_of(d);
        st    = idx % NSTEP;
        t     = (idx / NSTEP) % tl;
        f     = idx / (NSTEP * tl);
        kx    = st % 3;
        ky    = (st / 3) % 3;
        ch    = st / 9;
        p0    = t * npe;
        e.ox  = p0 % w;
        e.oy  = p0 / w;
        e.ifm = ((e.oy * s + ky) * iw + e.ox * s + kx + ch * iw * iw) % 65536;
        e.wa  = f * NSTEP + st;
        e.cnt = (w * w - p0 < npe) ? w * w - p0 : npe;
        e.rs  = (st == 0);
        e.fin = (st == NSTEP - 1);
        return e;
    endfunction

    task automatic chk(input string name, input int d, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h want %0h", name, d, act, exp);
        end
    endtask

    task automatic check_dut(input int d, input logic st, input logic rdy, input logic v,
                             input logic [15:0] ia, input logic [11:0] wa, input logic [15:0] x,
                             input logic [15:0] y, input logic [255:0] m, input logic rsr,
                             input logic fin, input logic td, input logic dn, input logic bz);
        exp_t e;
        logic [317:0] cur;
        cur = {ia, wa, x, y, m, rsr, fin};
        if (rst) begin
            chk("outputs under reset", d, 320'({cur, v, td, dn, bz}), 320'(0));
            run[d] = 1'b0; etd[d] = 1'b0; edone[d] = 1'b0; stall[d] = 1'b0; n[d] = 0;
        end else begin
            chk("step_valid", d, 320'(v), 320'(run[d]));
            chk("busy", d, 320'(bz), 320'(run[d]));
            chk("tile_done", d, 320'(td), 320'(etd[d]));
            chk("done", d, 320'(dn), 320'(edone[d]));
            e = model(d, n[d]);
            if (run[d]) begin
                chk("ifm_addr", d, 320'(ia), 320'(16'(e.ifm)));
                chk("weight_addr", d, 320'(wa), 320'(12'(e.wa)));
                chk("ox0", d, 320'(x), 320'(16'(e.ox)));
                chk("oy0", d, 320'(y), 320'(16'(e.oy)));
                chk("pe_mask", d, 320'(m), 320'(ones >> (256 - e.cnt)));
                chk("pe_restart", d, 320'(rsr), 320'(e.rs));
                chk("pe_finish", d, 320'(fin), 320'(e.fin));
                if (stall[d])
                    chk("hold while stalled", d, 320'(cur), 320'(snap[d]));
                if (replay[d] && rdy) begin
                    chk("replay ifm_addr", d, 320'(ia), 320'(16'(o_ifm[d][n[d]])));
                    chk("replay weight_addr", d, 320'(wa), 320'(12'(o_wa[d][n[d]])));
                end
                if (cap[d] && rdy) begin
                    o_ifm[d][n[d]] = int'(ia);
                    o_wa[d][n[d]]  = int'(wa);
                    o_ox[d][n[d]]  = int'(x);
                    o_oy[d][n[d]]  = int'(y);
                    o_m[d][n[d]]   = m;
                    o_rs[d][n[d]]  = rsr;
                    o_fin[d][n[d]] = fin;
                    hs[d]++;
                end
                snap[d] = cur;
            end
            stall[d] = run[d] && !rdy;
            etd[d]   = 1'b0;
            edone[d] = 1'b0;
            if (!run[d] && st) begin
                run[d] = 1'b1;
                n[d]   = 0;
            end else if (run[d] && rdy) begin
                etd[d] = e.fin;
                if (n[d] == total_of(d) - 1) begin
                    run[d]   = 1'b0;
                    edone[d] = 1'b1;
                end else begin
                    n[d]++;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        check_dut(0, start_a, rdy_a, a_v, a_ifm, a_w, a_ox, a_oy, a_m, a_rs, a_fin, a_td, a_dn, a_bz);
        check_dut(1, start_b, rdy_b, b_v, b_ifm, b_w, b_ox, b_oy, 256'(b_m), b_rs, b_fin, b_td, b_dn, b_bz);
        check_dut(2, start_c, rdy_c, c_v, c_ifm, c_w_o, c_ox, c_oy, 256'(c_m), c_rs, c_fin, c_td, c_dn, c_bz);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int d = 0; d < 3; d++) cap[d] = 1'b1;
        @(posedge clk); #1 {start_a, start_b, start_c} = 3'b111;
        @(posedge clk); #1 {start_a, start_b, start_c} = 3'b000;
        for (int i = 0; i < 2000 && (run[0] || run[1] || run[2]); i++) begin
            start_a = run[0] && n[0] == 215;
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        chk("ready-high layers complete", 0, 320'({run[0], run[1], run[2]}), 320'(0));
        for (int d = 0; d < 3; d++) cap[d] = 1'b0;

        chk("A step count", 0, 320'(hs[0]), 320'(216));
        chk("A s1 ifm", 0, 320'(o_ifm[0][0]), 320'(0));
        chk("A s1 weight", 0, 320'(o_wa[0][0]), 320'(0));
        chk("A s1 restart", 0, 320'(o_rs[0][0]), 320'(1));
        chk("A s1 mask", 0, 320'(o_m[0][0]), 320'(ones));
        chk("A s2 ifm", 0, 320'(o_ifm[0][1]), 320'(1));
        chk("A s4 ifm", 0, 320'(o_ifm[0][3]), 320'(34));
        chk("A s10 ifm", 0, 320'(o_ifm[0][9]), 320'(1156));
        chk("A s27 finish", 0, 320'(o_fin[0][26]), 320'(1));
        chk("A tile1 ox0", 0, 320'(o_ox[0][27]), 320'(0));
        chk("A tile1 oy0", 0, 320'(o_oy[0][27]), 320'(8));
        chk("A tile1 ifm", 0, 320'(o_ifm[0][27]), 320'(272));
        chk("A tile1 weight", 0, 320'(o_wa[0][27]), 320'(0));
        chk("A tile1 restart", 0, 320'(o_rs[0][27]), 320'(1));
        chk("A filter1 weight", 0, 320'(o_wa[0][108]), 320'(27));
        chk("A filter1 oy0", 0, 320'(o_oy[0][108]), 320'(0));
        chk("B step count", 1, 320'(hs[1]), 320'(108));
        chk("B tile1 mask", 1, 320'(o_m[1][27]), 320'(64'h0000_000F_FFFF_FFFF));
        chk("B tile1 ox0", 1, 320'(o_ox[1][27]), 320'(4));
        chk("B tile1 oy0", 1, 320'(o_oy[1][27]), 320'(6));
        chk("C step count", 2, 320'(hs[2]), 320'(864));
        chk("C tile1 oy0", 2, 320'(o_oy[2][27]), 320'(1));
        chk("C tile1 ifm", 2, 320'(o_ifm[2][27]), 320'(66));

        replay[0] = 1'b1;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        for (int i = 0; i < 3000 && run[0]; i++) begin
            rdy_a = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        chk("backpressured layer completes", 0, 320'(run[0]), 320'(0));
        replay[0] = 1'b0;
        rdy_a     = 1'b1;

        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (40) @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async reset clears", 0,
            320'({a_ifm, a_w, a_ox, a_oy, a_m, a_rs, a_fin, a_v, a_td, a_dn, a_bz}), 320'(0));
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        chk("restart valid", 0, 320'(a_v), 320'(1));
        chk("restart ifm", 0, 320'(a_ifm), 320'(0));
        chk("restart weight", 0, 320'(a_w), 320'(0));
        chk("restart pe_restart", 0, 320'(a_rs), 320'(1));
        @(posedge clk); #1;
        chk("restart s2 ifm", 0, 320'(a_ifm), 320'(1));
        for (int i = 0; i < 500 && run[0]; i++) begin
            @(posedge clk); #1;
        end
        chk("replayed layer completes", 0, 320'(run[0]), 320'(0));
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
